seq_feeder: RTL and testbench

SEQ_FEEDER -- requirements
Module: seq_feeder

---
 rtl/seq_feeder.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_seq_feeder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_feeder.sv
// seq_feeder: loads a T sequence into an on-chip {t, v, f} buffer, then feeds
// the PE array one S chunk at a time. For each chunk it presents the packed S
// characters once and then streams the whole T buffer. Boundary v/f values
// returned by the array are written back so the next chunk sees them.
module seq_feeder #(
    parameter int PE_NUM      = 64,
    parameter int PE_NUM_LOG  = 6,
    parameter int VEF_BIT     = 16,
    parameter int T_DEPTH_LOG = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [VEF_BIT-1:0]      i_minusAlpha,
    input  logic [1:0]              i_t_data,
    input  logic                    i_t_valid,
    input  logic                    i_t_last,
    output logic                    o_t_ready,
    input  logic [1:0]              i_s_data,
    input  logic                    i_s_valid,
    input  logic                    i_s_last,
    output logic                    o_s_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [PE_NUM*2-1:0]     o_s,
    output logic                    o_s_valid,
    output logic                    o_s_last,
    output logic [PE_NUM_LOG-1:0]   o_s_addr,
    output logic [1:0]              o_t,
    output logic [VEF_BIT-1:0]      o_v,
    output logic [VEF_BIT-1:0]      o_f,
    output logic [VEF_BIT-1:0]      o_v_a,
    output logic                    o_t_newline,
    output logic                    o_enable_0,
    output logic                    o_lock,
    input  logic [VEF_BIT-1:0]      i_ret_v,
    input  logic [VEF_BIT-1:0]      i_ret_f,
    input  logic                    i_ret_valid
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_T   = 3'd1,
        LOAD_S   = 3'd2,
        SEND_S   = 3'd3,
        STREAM_T = 3'd4,
        DRAIN    = 3'd5,
        DONE     = 3'd6
    } state_e;

    localparam int T_DEPTH = 1 << T_DEPTH_LOG;

    localparam logic [T_DEPTH_LOG-1:0] PTR_ONE = T_DEPTH_LOG'(1);
    localparam logic [T_DEPTH_LOG-1:0] PTR_MAX = T_DEPTH_LOG'(T_DEPTH - 1);
    localparam logic [T_DEPTH_LOG:0]   LEN_ONE = (T_DEPTH_LOG + 1)'(1);
    localparam logic [PE_NUM_LOG-1:0]  CNT_ONE = PE_NUM_LOG'(1);
    localparam logic [PE_NUM_LOG-1:0]  CNT_MAX = PE_NUM_LOG'(PE_NUM - 1);

    // T buffer storage, split per field so a write-back touches only v/f
    logic [1:0]         mem_t_q [T_DEPTH];
    logic [VEF_BIT-1:0] mem_v_q [T_DEPTH];
    logic [VEF_BIT-1:0] mem_f_q [T_DEPTH];

    state_e                  state_q, state_d;
    logic [T_DEPTH_LOG-1:0]  wr_ptr_q;
    logic [T_DEPTH_LOG:0]    t_len_q;
    logic [T_DEPTH_LOG-1:0]  rd_ptr_q;
    logic [T_DEPTH_LOG:0]    wb_ptr_q;
    logic [PE_NUM_LOG-1:0]   cnt_q;
    logic                    last_q;
    logic [PE_NUM*2-1:0]     s_buf_q;

    logic                    o_t_ready_q;
    logic                    o_s_ready_q;
    logic                    o_busy_q;
    logic                    o_done_q;
    logic                    o_s_valid_q;
    logic                    o_lock_q;
    logic [1:0]              o_t_q;
    logic [VEF_BIT-1:0]      o_v_q;
    logic [VEF_BIT-1:0]      o_f_q;
    logic [VEF_BIT-1:0]      o_v_a_q;
    logic                    o_t_newline_q;
    logic                    o_enable_0_q;

    logic                    t_acc_s;
    logic                    t_end_s;
    logic                    s_acc_s;
    logic                    s_end_s;
    logic                    ret_acc_s;
    logic                    stream_end_s;
    logic                    drain_end_s;
    logic                    load_s;
    logic [T_DEPTH_LOG-1:0]  rd_addr_s;
    logic [T_DEPTH_LOG-1:0]  wb_idx_s;
    logic [1:0]              rd_t_s;
    logic [VEF_BIT-1:0]      rd_v_s;
    logic [VEF_BIT-1:0]      rd_f_s;

    // Handshake qualifiers and buffer read address (one entry ahead of the output register)
    always_comb begin
        t_acc_s      = (state_q == LOAD_T) && i_t_valid;
        // The final buffer entry ends the T load even without i_t_last
        t_end_s      = t_acc_s && (i_t_last || (wr_ptr_q == PTR_MAX));
        s_acc_s      = (state_q == LOAD_S) && i_s_valid;
        s_end_s      = s_acc_s && (i_s_last || (cnt_q == CNT_MAX));
        // Returns beyond t_len would corrupt unused entries, so they are dropped
        ret_acc_s    = ((state_q == STREAM_T) || (state_q == DRAIN)) && i_ret_valid
                       && (wb_ptr_q < t_len_q);
        stream_end_s = (state_q == STREAM_T) && ({1'b0, rd_ptr_q} == (t_len_q - LEN_ONE));
        drain_end_s  = (state_q == DRAIN) && (wb_ptr_q == t_len_q);
        // Entering STREAM_T prefetches entry 0; each non-final stream cycle prefetches the next
        load_s       = (state_q == SEND_S) || ((state_q == STREAM_T) && !stream_end_s);
        if (state_q == SEND_S) begin
            rd_addr_s = '0;
        end else begin
            rd_addr_s = rd_ptr_q + PTR_ONE;
        end
        wb_idx_s     = wb_ptr_q[T_DEPTH_LOG-1:0];
        // Plain read of stored contents: a same-cycle write to this address
        // lands in the buffer but is not forwarded to this read
        rd_t_s       = mem_t_q[rd_addr_s];
        rd_v_s       = mem_v_q[rd_addr_s];
        rd_f_s       = mem_f_q[rd_addr_s];
    end

    // Next-state selection for the job sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = LOAD_T;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_T: begin
                if (t_end_s) begin
                    state_d = LOAD_S;
                end else begin
                    state_d = LOAD_T;
                end
            end
            LOAD_S: begin
                if (s_end_s) begin
                    state_d = SEND_S;
                end else begin
                    state_d = LOAD_S;
                end
            end
            SEND_S: begin
                state_d = STREAM_T;
            end
            STREAM_T: begin
                if (stream_end_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = STREAM_T;
                end
            end
            DRAIN: begin
                if (drain_end_s) begin
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD_S;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // T buffer write port: host load during LOAD_T, array write-back during STREAM_T/DRAIN
    always_ff @(posedge clk) begin
        if (t_acc_s) begin
            mem_t_q[wr_ptr_q] <= i_t_data;
            mem_v_q[wr_ptr_q] <= '0;
            mem_f_q[wr_ptr_q] <= '0;
        end else if (ret_acc_s) begin
            mem_v_q[wb_idx_s] <= i_ret_v;
            mem_f_q[wb_idx_s] <= i_ret_f;
        end
    end

    // Sequencer state, pointers, S chunk assembly and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            t_len_q       <= '0;
            rd_ptr_q      <= '0;
            wb_ptr_q      <= '0;
            cnt_q         <= '0;
            last_q        <= 1'b0;
            s_buf_q       <= '0;
            o_t_ready_q   <= 1'b0;
            o_s_ready_q   <= 1'b0;
            o_busy_q      <= 1'b0;
            o_done_q      <= 1'b0;
            o_s_valid_q   <= 1'b0;
            o_lock_q      <= 1'b1;
            o_t_q         <= 2'b00;
            o_v_q         <= '0;
            o_f_q         <= '0;
            o_v_a_q       <= '0;
            o_t_newline_q <= 1'b0;
            o_enable_0_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_t_ready_q <= (state_d == LOAD_T);
            o_s_ready_q <= (state_d == LOAD_S);
            o_s_valid_q <= (state_d == SEND_S);
            o_done_q    <= (state_d == DONE);
            o_busy_q    <= (state_d != IDLE);
            o_lock_q    <= !((state_d == STREAM_T) || (state_d == DRAIN));

            if ((state_q == IDLE) && i_start) begin
                wr_ptr_q <= '0;
                t_len_q  <= '0;
                last_q   <= 1'b0;
            end

            if (t_acc_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                t_len_q  <= {1'b0, wr_ptr_q} + LEN_ONE;
            end

            // A fresh chunk starts empty so unfilled PE slots carry zero
            if (t_end_s || (drain_end_s && !last_q)) begin
                cnt_q   <= '0;
                s_buf_q <= '0;
            end

            if (s_acc_s) begin
                s_buf_q[{cnt_q, 1'b0} +: 2] <= i_s_data;
                if (s_end_s) begin
                    last_q <= i_s_last;
                end else begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end

            if (state_q == SEND_S) begin
                rd_ptr_q <= '0;
                wb_ptr_q <= '0;
            end else if ((state_q == STREAM_T) && !stream_end_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end

            if (ret_acc_s) begin
                wb_ptr_q <= wb_ptr_q + LEN_ONE;
            end

            o_enable_0_q  <= load_s;
            o_t_newline_q <= (state_q == SEND_S);
            if (load_s) begin
                o_t_q   <= rd_t_s;
                o_v_q   <= rd_v_s;
                o_f_q   <= rd_f_s;
                // Plain modular add: overflow wraps, no saturation
                o_v_a_q <= rd_v_s + i_minusAlpha;
            end
        end
    end

    assign o_t_ready   = o_t_ready_q;
    assign o_s_ready   = o_s_ready_q;
    assign o_busy      = o_busy_q;
    assign o_done      = o_done_q;
    assign o_s         = s_buf_q;
    assign o_s_valid   = o_s_valid_q;
    assign o_s_last    = last_q;
    assign o_s_addr    = cnt_q;
    assign o_t         = o_t_q;
    assign o_v         = o_v_q;
    assign o_f         = o_f_q;
    assign o_v_a       = o_v_a_q;
    assign o_t_newline = o_t_newline_q;
    assign o_enable_0  = o_enable_0_q;
    assign o_lock      = o_lock_q;

endmodule

// File: tb/tb_seq_feeder.sv
// Directed testbench for seq_feeder: fixed T/S jobs with hand-computed
// expected chunk packing, streamed entries, write-back and job completion.
module tb_seq_feeder;

    localparam int PE_NUM      = 64;
    localparam int PE_NUM_LOG  = 6;
    localparam int VEF_BIT     = 16;
    localparam int T_DEPTH_LOG = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  i_start;
    logic [VEF_BIT-1:0]    i_minusAlpha;
    logic [1:0]            i_t_data;
    logic                  i_t_valid;
    logic                  i_t_last;
    logic                  o_t_ready;
    logic [1:0]            i_s_data;
    logic                  i_s_valid;
    logic                  i_s_last;
    logic                  o_s_ready;
    logic                  o_busy;
    logic                  o_done;
    logic [PE_NUM*2-1:0]   o_s;
    logic                  o_s_valid;
    logic                  o_s_last;
    logic [PE_NUM_LOG-1:0] o_s_addr;
    logic [1:0]            o_t;
    logic [VEF_BIT-1:0]    o_v;
    logic [VEF_BIT-1:0]    o_f;
    logic [VEF_BIT-1:0]    o_v_a;
    logic                  o_t_newline;
    logic                  o_enable_0;
    logic                  o_lock;
    logic [VEF_BIT-1:0]    i_ret_v;
    logic [VEF_BIT-1:0]    i_ret_f;
    logic                  i_ret_valid;

    int n_vec = 0;
    int n_err = 0;

    // Expected stream contents and values to return, filled per job
    logic [1:0]         et [16];
    logic [VEF_BIT-1:0] ev [16];
    logic [VEF_BIT-1:0] ef [16];
    logic [VEF_BIT-1:0] rv [16];
    logic [VEF_BIT-1:0] rf [16];

    seq_feeder #(
        .PE_NUM      (PE_NUM),
        .PE_NUM_LOG  (PE_NUM_LOG),
        .VEF_BIT     (VEF_BIT),
        .T_DEPTH_LOG (T_DEPTH_LOG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_minusAlpha (i_minusAlpha),
        .i_t_data     (i_t_data),
        .i_t_valid    (i_t_valid),
        .i_t_last     (i_t_last),
        .o_t_ready    (o_t_ready),
        .i_s_data     (i_s_data),
        .i_s_valid    (i_s_valid),
        .i_s_last     (i_s_last),
        .o_s_ready    (o_s_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_s          (o_s),
        .o_s_valid    (o_s_valid),
        .o_s_last     (o_s_last),
        .o_s_addr     (o_s_addr),
        .o_t          (o_t),
        .o_v          (o_v),
        .o_f          (o_f),
        .o_v_a        (o_v_a),
        .o_t_newline  (o_t_newline),
        .o_enable_0   (o_enable_0),
        .o_lock       (o_lock),
        .i_ret_v      (i_ret_v),
        .i_ret_f      (i_ret_f),
        .i_ret_valid  (i_ret_valid)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_t_ready", 128'(o_t_ready), 128'(1));
        chk("start_busy", 128'(o_busy), 128'(1));
    endtask

    task automatic t_beat(input logic [1:0] d, input logic last);
        i_t_data  = d;
        i_t_last  = last;
        i_t_valid = 1'b1;
        tick();
        i_t_valid = 1'b0;
        i_t_last  = 1'b0;
    endtask

    task automatic s_beat(input logic [1:0] d, input logic last);
        i_s_data  = d;
        i_s_last  = last;
        i_s_valid = 1'b1;
        tick();
        i_s_valid = 1'b0;
        i_s_last  = 1'b0;
    endtask

    // Called in the SEND_S cycle: checks the chunk, then checks n streamed entries
    task automatic send_and_stream(input string tag, input logic [127:0] s_exp,
                                   input int addr_exp, input logic last_exp,
                                   input int n, input logic [VEF_BIT-1:0] alpha);
        chk({tag, "_s_valid"}, 128'(o_s_valid), 128'(1));
        chk({tag, "_s"}, o_s, s_exp);
        chk({tag, "_s_addr"}, 128'(o_s_addr), 128'(addr_exp));
        chk({tag, "_s_last"}, 128'(o_s_last), 128'(last_exp));
        tick();
        chk({tag, "_s_valid_off"}, 128'(o_s_valid), 128'(0));
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_en%0d", tag, k), 128'(o_enable_0), 128'(1));
            chk($sformatf("%s_nl%0d", tag, k), 128'(o_t_newline), 128'(k == 0));
            chk($sformatf("%s_lock%0d", tag, k), 128'(o_lock), 128'(0));
            chk($sformatf("%s_t%0d", tag, k), 128'(o_t), 128'(et[k]));
            chk($sformatf("%s_v%0d", tag, k), 128'(o_v), 128'(ev[k]));
            chk($sformatf("%s_f%0d", tag, k), 128'(o_f), 128'(ef[k]));
            chk($sformatf("%s_va%0d", tag, k), 128'(o_v_a), 128'(16'(ev[k] + alpha)));
            tick();
        end
        chk({tag, "_drain_en"}, 128'(o_enable_0), 128'(0));
        chk({tag, "_drain_nl"}, 128'(o_t_newline), 128'(0));
        chk({tag, "_drain_lock"}, 128'(o_lock), 128'(0));
    endtask

    task automatic returns(input int n);
        for (int k = 0; k < n; k++) begin
            i_ret_v     = rv[k];
            i_ret_f     = rf[k];
            i_ret_valid = 1'b1;
            tick();
        end
        i_ret_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        tick();
        chk({tag, "_done"}, 128'(o_done), 128'(1));
        chk({tag, "_done_busy"}, 128'(o_busy), 128'(1));
        tick();
        chk({tag, "_done_pulse"}, 128'(o_done), 128'(0));
        chk({tag, "_idle_busy"}, 128'(o_busy), 128'(0));
        chk({tag, "_idle_lock"}, 128'(o_lock), 128'(1));
    endtask

    initial begin
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_minusAlpha = 16'hFFFB;
        i_t_data     = 2'd0;
        i_t_valid    = 1'b0;
        i_t_last     = 1'b0;
        i_s_data     = 2'd0;
        i_s_valid    = 1'b0;
        i_s_last     = 1'b0;
        i_ret_v      = 16'h0000;
        i_ret_f      = 16'h0000;
        i_ret_valid  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_lock", 128'(o_lock), 128'(1));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_done", 128'(o_done), 128'(0));
        chk("rst_s_valid", 128'(o_s_valid), 128'(0));
        chk("rst_en", 128'(o_enable_0), 128'(0));
        chk("rst_t_ready", 128'(o_t_ready), 128'(0));
        chk("rst_s_ready", 128'(o_s_ready), 128'(0));
        rst_n = 1'b1;
        tick();

        // Job 1: T = A C G, S = 5 chars, single pass
        start_job();
        t_beat(2'd0, 1'b0);
        t_beat(2'd1, 1'b0);
        t_beat(2'd2, 1'b1);
        chk("j1_s_ready", 128'(o_s_ready), 128'(1));
        chk("j1_t_ready", 128'(o_t_ready), 128'(0));
        s_beat(2'd3, 1'b0);
        s_beat(2'd2, 1'b0);
        s_beat(2'd1, 1'b0);
        s_beat(2'd0, 1'b0);
        s_beat(2'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            et[k] = 2'(k);
            ev[k] = 16'h0000;
            ef[k] = 16'h0000;
            rv[k] = 16'(16'h0100 + k);
            rf[k] = 16'(16'h0200 + k);
        end
        send_and_stream("j1", 128'h31B, 4, 1'b1, 3, 16'hFFFB);
        returns(3);
        expect_done("j1");

        // Job 2: T = T C, S = PE_NUM+1 chars, two passes, wrap on o_v_a
        i_minusAlpha = 16'h0001;
        start_job();
        t_beat(2'd3, 1'b0);
        t_beat(2'd1, 1'b1);
        for (int k = 0; k < PE_NUM; k++) begin
            s_beat(2'(k % 4), 1'b0);
        end
        et[0] = 2'd3; ev[0] = 16'h0000; ef[0] = 16'h0000;
        et[1] = 2'd1; ev[1] = 16'h0000; ef[1] = 16'h0000;
        rv[0] = 16'h0011; rf[0] = 16'h0022;
        rv[1] = 16'h7FFF; rf[1] = 16'h1234;
        send_and_stream("j2p1", {16{8'hE4}}, 63, 1'b0, 2, 16'h0001);
        returns(2);
        tick();
        chk("j2_next_s_ready", 128'(o_s_ready), 128'(1));
        chk("j2_next_no_done", 128'(o_done), 128'(0));
        chk("j2_next_lock", 128'(o_lock), 128'(1));
        chk("j2_next_s_clear", o_s, 128'h0);
        s_beat(2'd2, 1'b1);
        ev[0] = 16'h0011; ef[0] = 16'h0022;
        ev[1] = 16'h7FFF; ef[1] = 16'h1234;
        rv[0] = 16'h0005; rf[0] = 16'h0006;
        rv[1] = 16'h0007; rf[1] = 16'h0008;
        send_and_stream("j2p2", 128'h2, 0, 1'b1, 2, 16'h0001);
        chk("j2_wrap_va", 128'(o_v_a), 128'h8000);
        returns(2);
        expect_done("j2");

        // Job 3: single-char T, stray start ignored while busy
        i_minusAlpha = 16'hFFFE;
        start_job();
        t_beat(2'd2, 1'b1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("j3_stray_start_s_ready", 128'(o_s_ready), 128'(1));
        chk("j3_stray_start_t_ready", 128'(o_t_ready), 128'(0));
        s_beat(2'd1, 1'b1);
        et[0] = 2'd2; ev[0] = 16'h0000; ef[0] = 16'h0000;
        rv[0] = 16'h0033; rf[0] = 16'h0044;
        send_and_stream("j3", 128'h1, 0, 1'b1, 1, 16'hFFFE);
        returns(1);
        expect_done("j3");

        // Job 4: reset while streaming abandons the job
        start_job();
        t_beat(2'd1, 1'b0);
        t_beat(2'd0, 1'b1);
        s_beat(2'd3, 1'b1);
        chk("j4_s_valid", 128'(o_s_valid), 128'(1));
        tick();
        chk("j4_streaming", 128'(o_enable_0), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("j4_rst_lock", 128'(o_lock), 128'(1));
        chk("j4_rst_busy", 128'(o_busy), 128'(0));
        chk("j4_rst_en", 128'(o_enable_0), 128'(0));
        tick();
        chk("j4_rst_hold_busy", 128'(o_busy), 128'(0));
        rst_n = 1'b1;
        tick();
        chk("j4_after_rst_idle", 128'(o_busy), 128'(0));

        // Job 5: T fills the buffer without i_t_last
        i_minusAlpha = 16'hFFFB;
        start_job();
        for (int k = 0; k < 8; k++) begin
            t_beat(2'((k + 1) % 4), 1'b0);
        end
        chk("j5_full_s_ready", 128'(o_s_ready), 128'(1));
        chk("j5_full_t_ready", 128'(o_t_ready), 128'(0));
        s_beat(2'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            et[k] = 2'((k + 1) % 4);
            ev[k] = 16'h0000;
            ef[k] = 16'h0000;
            rv[k] = 16'(k);
            rf[k] = 16'(k + 8);
        end
        send_and_stream("j5", 128'h0, 0, 1'b1, 8, 16'hFFFB);
        returns(8);
        expect_done("j5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
